// File: rtl/tpu_pkg.sv
// Shared TPU definitions: input-staging FSM states and default datapath sizes.
package tpu_pkg;

  localparam int unsigned DefArrayDim = 2;
  localparam int unsigned DefDataW    = 16;
  localparam int unsigned DefMemW     = 32;
  localparam int unsigned DefAddrW    = 6;
  localparam int unsigned DefMaxVecs  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFeed,
    StDrain,
    StDone
  } setup_state_t;

endpackage

// File: rtl/setup_buffer.sv
// Local activation store: MAX_VECS x ARRAY_DIM entries, one write port and one
// combinational read port per lane.
module setup_buffer #(
  parameter int unsigned ARRAY_DIM = 2,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_VECS  = 8,
  localparam int unsigned VecIdxW  = (MAX_VECS > 1) ? $clog2(MAX_VECS) : 1,
  localparam int unsigned LaneW    = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_we,
  input  logic [VecIdxW-1:0]            i_wr_vec,
  input  logic [LaneW-1:0]              i_wr_lane,
  input  logic [DATA_W-1:0]             i_wr_data,
  input  logic [ARRAY_DIM*VecIdxW-1:0]  i_rd_vec,
  output logic [ARRAY_DIM*DATA_W-1:0]   o_rd_data
);

  logic [DATA_W-1:0] r_mem [MAX_VECS][ARRAY_DIM];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_vec][i_wr_lane] <= i_wr_data;
    end
  end

  // Write-through lets the first feed beat see an element captured on the same edge.
  always_comb begin
    o_rd_data = '0;
    for (int k = 0; k < ARRAY_DIM; k++) begin
      if (i_we && (i_wr_vec == i_rd_vec[k*VecIdxW +: VecIdxW]) && (i_wr_lane == LaneW'(k))) begin
        o_rd_data[k*DATA_W +: DATA_W] = i_wr_data;
      end else begin
        o_rd_data[k*DATA_W +: DATA_W] = r_mem[i_rd_vec[k*VecIdxW +: VecIdxW]][k];
      end
    end
  end

endmodule

// File: rtl/systolic_input_setup.sv
// Stages activation vectors from the unified buffer and feeds them diagonally
// skewed into the systolic array's west edge, followed by zero drain beats.
module systolic_input_setup
  import tpu_pkg::*;
#(
  parameter int unsigned ARRAY_DIM  = DefArrayDim,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned MEM_W      = DefMemW,
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned MAX_VECS   = DefMaxVecs,
  localparam int unsigned VEC_CNT_W = $clog2(MAX_VECS + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [ADDR_W-1:0]           i_base_addr,
  input  logic [VEC_CNT_W-1:0]        i_num_vecs,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_cfg_err,
  output logic                        o_mem_rd_en,
  output logic [ADDR_W-1:0]           o_mem_rd_addr,
  input  logic [MEM_W-1:0]            i_mem_rd_data,
  output logic                        o_a_valid,
  output logic                        o_a_drain,
  output logic [ARRAY_DIM*DATA_W-1:0] o_a_out
);

  localparam int unsigned VecIdxW = (MAX_VECS > 1) ? $clog2(MAX_VECS) : 1;
  localparam int unsigned LaneW   = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam int unsigned CntW    = $clog2(MAX_VECS * ARRAY_DIM + 1);
  localparam int unsigned FW      = $clog2(MAX_VECS + ARRAY_DIM);

  setup_state_t                r_state;
  logic [VEC_CNT_W-1:0]        r_nv;
  logic [CntW-1:0]             r_len;
  logic [CntW-1:0]             r_cnt;
  logic [FW-1:0]               r_f;
  logic [VecIdxW-1:0]          r_wr_vec;
  logic [LaneW-1:0]            r_wr_lane;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_cfg_err;
  logic                        r_rd_en;
  logic [ADDR_W-1:0]           r_rd_addr;
  logic                        r_a_valid;
  logic                        r_a_drain;
  logic [ARRAY_DIM*DATA_W-1:0] r_a_out;

  logic                        w_we;
  logic                        w_cfg_bad;
  logic [FW-1:0]               w_g;
  logic [FW-1:0]               w_f_end;
  logic [ARRAY_DIM*VecIdxW-1:0] w_rd_vec;
  logic [ARRAY_DIM*DATA_W-1:0] w_rd_data;
  logic [ARRAY_DIM*DATA_W-1:0] w_lanes;

  if (MEM_W > DATA_W) begin : g_unused_hi
    logic w_unused_hi;
    assign w_unused_hi = ^i_mem_rd_data[MEM_W-1:DATA_W];
  end

  // Read data lags the request by one cycle, so LOAD cycle c captures element c-1.
  assign w_we      = (r_state == StLoad) && (r_cnt != '0);
  assign w_cfg_bad = (i_num_vecs == '0) || (i_num_vecs > VEC_CNT_W'(MAX_VECS));
  assign w_g       = (r_state == StLoad) ? '0 : r_f + FW'(1);
  assign w_f_end   = FW'(r_nv) + FW'(ARRAY_DIM) - FW'(2);

  // Lane k at feed step g carries vector g-k when that vector exists.
  always_comb begin
    w_rd_vec = '0;
    w_lanes  = '0;
    for (int k = 0; k < ARRAY_DIM; k++) begin
      w_rd_vec[k*VecIdxW +: VecIdxW] = VecIdxW'(int'(w_g) - k);
      if ((int'(w_g) >= k) && ((int'(w_g) - k) < int'(r_nv))) begin
        w_lanes[k*DATA_W +: DATA_W] = w_rd_data[k*DATA_W +: DATA_W];
      end
    end
  end

  setup_buffer #(
    .ARRAY_DIM (ARRAY_DIM),
    .DATA_W    (DATA_W),
    .MAX_VECS  (MAX_VECS)
  ) u_buffer (
    .i_clk     (i_clk),
    .i_we      (w_we),
    .i_wr_vec  (r_wr_vec),
    .i_wr_lane (r_wr_lane),
    .i_wr_data (i_mem_rd_data[DATA_W-1:0]),
    .i_rd_vec  (w_rd_vec),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= StIdle;
      r_nv      <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_f       <= '0;
      r_wr_vec  <= '0;
      r_wr_lane <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_a_valid <= 1'b0;
      r_a_drain <= 1'b0;
      r_a_out   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      if (w_we) begin
        if (r_wr_lane == LaneW'(ARRAY_DIM - 1)) begin
          r_wr_lane <= '0;
          r_wr_vec  <= r_wr_vec + VecIdxW'(1);
        end else begin
          r_wr_lane <= r_wr_lane + LaneW'(1);
        end
      end
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            if (w_cfg_bad) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_state   <= StLoad;
              r_busy    <= 1'b1;
              r_rd_en   <= 1'b1;
              r_rd_addr <= i_base_addr;
              r_nv      <= i_num_vecs;
              r_len     <= CntW'(i_num_vecs) * CntW'(ARRAY_DIM);
              r_cnt     <= '0;
              r_wr_vec  <= '0;
              r_wr_lane <= '0;
            end
          end
        end
        StLoad: begin
          if (r_cnt == r_len) begin
            r_state   <= StFeed;
            r_a_valid <= 1'b1;
            r_a_out   <= w_lanes;
            r_f       <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
            if (r_cnt + CntW'(1) == r_len) begin
              r_rd_en <= 1'b0;
            end else begin
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
          end
        end
        StFeed: begin
          if (r_f == w_f_end) begin
            r_state   <= StDrain;
            r_a_out   <= '0;
            r_a_drain <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_f     <= r_f + FW'(1);
            r_a_out <= w_lanes;
          end
        end
        StDrain: begin
          if (r_cnt == CntW'(ARRAY_DIM - 1)) begin
            r_state   <= StDone;
            r_busy    <= 1'b0;
            r_a_valid <= 1'b0;
            r_a_drain <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_cfg_err     = r_cfg_err;
  assign o_mem_rd_en   = r_rd_en;
  assign o_mem_rd_addr = r_rd_addr;
  assign o_a_valid     = r_a_valid;
  assign o_a_drain     = r_a_drain;
  assign o_a_out       = r_a_out;

endmodule

// File: tb/tb_systolic_input_setup.sv
// Scoreboard bench for systolic_input_setup: 2-lane and 4-lane instances.
module tb_systolic_input_setup;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          n_checks = 0;
  int          n_bad    = 0;

  // 2-lane instance
  logic        start2;
  logic [5:0]  base2;
  logic [3:0]  nv2;
  logic        busy2, done2, err2, rden2, valid2, drain2;
  logic [5:0]  addr2;
  logic [31:0] rdata2 = '0;
  logic [31:0] aout2;
  logic [31:0] mem2 [64];

  // 4-lane instance
  logic        start4;
  logic [5:0]  base4;
  logic [3:0]  nv4;
  logic        busy4, done4, err4, rden4, valid4, drain4;
  logic [5:0]  addr4;
  logic [31:0] rdata4 = '0;
  logic [63:0] aout4;
  logic [31:0] mem4 [64];

  logic [5:0]  q_addr2 [$];
  logic [32:0] q_out2  [$];
  logic [5:0]  q_addr4 [$];
  logic [64:0] q_out4  [$];

  systolic_input_setup #(
    .ARRAY_DIM (2), .DATA_W (16), .MEM_W (32), .ADDR_W (6), .MAX_VECS (8)
  ) u_dut2 (
    .i_clk (clk), .i_reset (rst_n), .i_start (start2), .i_base_addr (base2),
    .i_num_vecs (nv2), .o_busy (busy2), .o_done (done2), .o_cfg_err (err2),
    .o_mem_rd_en (rden2), .o_mem_rd_addr (addr2), .i_mem_rd_data (rdata2),
    .o_a_valid (valid2), .o_a_drain (drain2), .o_a_out (aout2)
  );

  systolic_input_setup #(
    .ARRAY_DIM (4), .DATA_W (16), .MEM_W (32), .ADDR_W (6), .MAX_VECS (8)
  ) u_dut4 (
    .i_clk (clk), .i_reset (rst_n), .i_start (start4), .i_base_addr (base4),
    .i_num_vecs (nv4), .o_busy (busy4), .o_done (done4), .o_cfg_err (err4),
    .o_mem_rd_en (rden4), .o_mem_rd_addr (addr4), .i_mem_rd_data (rdata4),
    .o_a_valid (valid4), .o_a_drain (drain4), .o_a_out (aout4)
  );

  always @(posedge clk) begin
    if (rden2) rdata2 <= mem2[addr2];
    if (rden4) rdata4 <= mem4[addr4];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    n_checks++;
    n_bad++;
    $display("FAIL %s: unexpected output %0h at %0t", name, act, $time);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a read or an array beat.
  always @(negedge clk) begin
    if (rden2) begin
      if (q_addr2.size() == 0) unexpected("rd_addr2", 128'(addr2));
      else check("rd_addr2", 128'(addr2), 128'(q_addr2.pop_front()));
    end
    if (valid2) begin
      if (q_out2.size() == 0) unexpected("a_out2", 128'({drain2, aout2}));
      else check("a_out2", 128'({drain2, aout2}), 128'(q_out2.pop_front()));
    end
    if (rden4) begin
      if (q_addr4.size() == 0) unexpected("rd_addr4", 128'(addr4));
      else check("rd_addr4", 128'(addr4), 128'(q_addr4.pop_front()));
    end
    if (valid4) begin
      if (q_out4.size() == 0) unexpected("a_out4", 128'({drain4, aout4}));
      else check("a_out4", 128'({drain4, aout4}), 128'(q_out4.pop_front()));
    end
  end

  task automatic exp2(input int l0, input int l1, input bit d);
    q_out2.push_back({d, 16'(l1), 16'(l0)});
  endtask

  task automatic exp_reads2(input int base, input int n);
    for (int i = 0; i < n; i++) q_addr2.push_back(6'(base + i));
  endtask

  task automatic start_dut2(input logic [5:0] base, input logic [3:0] nv);
    @(negedge clk);
    base2  = base;
    nv2    = nv;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
  endtask

  task automatic start_dut4(input logic [5:0] base, input logic [3:0] nv);
    @(negedge clk);
    base4  = base;
    nv4    = nv;
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
  endtask

  // Counts clock edges after the start edge until done is sampled high.
  task automatic wait_done(input bit sel4, input int lat, input string name);
    int n;
    bit seen;
    seen = 1'b0;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if ((sel4 ? done4 : done2) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) n = -1;
    check(name, 128'(n), 128'(lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    start2 = 1'b0; base2 = '0; nv2 = '0;
    start4 = 1'b0; base4 = '0; nv4 = '0;
    for (int i = 0; i < 64; i++) begin
      mem2[i] = {16'hA5A5, 16'(16'h0200 + i)};
      mem4[i] = {16'h5A5A, 16'(16'h0300 + i)};
    end
    #12;
    check("reset_outs2", 128'({busy2, done2, err2, rden2, valid2, drain2, addr2, aout2}), 128'(0));
    check("reset_outs4", 128'({busy4, done4, err4, rden4, valid4, drain4, addr4, aout4}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic job: two vectors at base 15
    mem2[15] = {16'hBEEF, 16'd11};
    mem2[16] = {16'hBEEF, 16'd21};
    mem2[17] = {16'hBEEF, 16'd12};
    mem2[18] = {16'hBEEF, 16'd22};
    exp_reads2(15, 4);
    exp2(11, 0, 0); exp2(12, 21, 0); exp2(0, 22, 0);
    exp2(0, 0, 1); exp2(0, 0, 1);
    start_dut2(6'd15, 4'd2);
    wait_done(1'b0, 11, "latency_basic");
    @(negedge clk);
    check("done_pulse", 128'({done2, busy2}), 128'(0));

    // Address wrap past the top of the buffer
    mem2[62] = {16'h7777, 16'h0031};
    mem2[63] = {16'h7777, 16'h0041};
    mem2[0]  = {16'h7777, 16'h0032};
    mem2[1]  = {16'h7777, 16'h0042};
    q_addr2.push_back(6'd62); q_addr2.push_back(6'd63);
    q_addr2.push_back(6'd0);  q_addr2.push_back(6'd1);
    exp2('h31, 0, 0); exp2('h32, 'h41, 0); exp2(0, 'h42, 0);
    exp2(0, 0, 1); exp2(0, 0, 1);
    start_dut2(6'd62, 4'd2);
    wait_done(1'b0, 11, "latency_wrap");

    // Illegal vector counts
    start_dut2(6'd3, 4'd0);
    @(negedge clk);
    check("cfg_err_zero", 128'({err2, busy2, rden2}), 128'(3'b100));
    @(negedge clk);
    check("cfg_err_zero_pulse", 128'({err2, busy2}), 128'(0));
    start_dut2(6'd3, 4'd9);
    @(negedge clk);
    check("cfg_err_over", 128'({err2, busy2, rden2}), 128'(3'b100));
    @(negedge clk);
    check("cfg_err_over_pulse", 128'({err2, busy2}), 128'(0));

    // Start during FEED and during DONE must be ignored
    for (int i = 0; i < 6; i++) mem2[20 + i] = {16'hCAFE, 16'(16'h0100 + i)};
    exp_reads2(20, 6);
    exp2('h100, 0, 0); exp2('h102, 'h101, 0); exp2('h104, 'h103, 0); exp2(0, 'h105, 0);
    exp2(0, 0, 1); exp2(0, 0, 1);
    start_dut2(6'd20, 4'd3);
    fork
      wait_done(1'b0, 14, "latency_ignored_start");
      begin
        repeat (9) @(negedge clk);
        base2  = 6'd40;
        nv2    = 4'd1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
      end
    join
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("start_in_done", 128'({busy2, rden2, done2}), 128'(0));
    @(negedge clk);
    check("start_in_done_idle", 128'({busy2, rden2}), 128'(0));

    // Asynchronous reset during LOAD cycle 2
    exp_reads2(30, 3);
    start_dut2(6'd30, 4'd2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", 128'({busy2, done2, err2, rden2, valid2, drain2, addr2, aout2}),
          128'(0));
    check("midrst_reads_seen", 128'(q_addr2.size()), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem2[5] = {16'h1234, 16'h0055};
    mem2[6] = {16'h1234, 16'h0066};
    exp_reads2(5, 2);
    exp2('h55, 0, 0); exp2(0, 'h66, 0);
    exp2(0, 0, 1); exp2(0, 0, 1);
    start_dut2(6'd5, 4'd1);
    wait_done(1'b0, 8, "latency_after_reset");

    // Four lanes, full depth
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 4; k++) begin
        mem4[v*4 + k] = {16'hFFFF, 16'(16'h0100 + v*16 + k)};
        q_addr4.push_back(6'(v*4 + k));
      end
    end
    for (int f = 0; f < 11; f++) begin
      logic [63:0] beat;
      beat = '0;
      for (int k = 0; k < 4; k++) begin
        if (f - k >= 0 && f - k < 8) beat[k*16 +: 16] = 16'(16'h0100 + (f - k)*16 + k);
      end
      q_out4.push_back({1'b0, beat});
    end
    for (int d = 0; d < 4; d++) q_out4.push_back({1'b1, 64'h0});
    start_dut4(6'd0, 4'd8);
    wait_done(1'b1, 49, "latency_dim4");

    repeat (3) @(negedge clk);
    check("left_addr2", 128'(q_addr2.size()), 128'(0));
    check("left_out2",  128'(q_out2.size()),  128'(0));
    check("left_addr4", 128'(q_addr4.size()), 128'(0));
    check("left_out4",  128'(q_out4.size()),  128'(0));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_input_setup.md
# systolic_input_setup

Parametrised input-staging unit between the unified buffer and the systolic array's west edge. On a start command it reads a block of activation vectors from the unified buffer into a local buffer. It then streams them into the array diagonally skewed, one lane per array row, followed by zero drain cycles that flush partial sums into the accumulators. This replaces manual zero padding of the input stream and generalises staging to any array dimension and vector count.

## Interface
- `ARRAY_DIM`, 2: array rows = output lanes = elements per vector
- `DATA_W`, 16: activation width per lane
- `MEM_W`, 32: unified-buffer word width; activation = low `DATA_W` bits (`DATA_W` ≤ `MEM_W`)
- `ADDR_W`, 6: unified-buffer address width
- `MAX_VECS`, 8: local buffer depth in vectors; `VEC_CNT_W` = clog2(`MAX_VECS`+1), derived

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `start` in 1: command strobe; accepted only in IDLE
- `base_addr` in `ADDR_W`: address of element (0,0)
- `num_vecs` in `VEC_CNT_W`: vector count; legal range 1..`MAX_VECS`
- `busy` out 1: high in LOAD, FEED and DRAIN
- `done` out 1: one-cycle completion pulse
- `cfg_err` out 1: one-cycle pulse when a start carries an illegal `num_vecs`
- `mem_rd_en` out 1: unified-buffer read request
- `mem_rd_addr` out `ADDR_W`: read address
- `mem_rd_data` in `MEM_W`: read data, valid exactly 1 cycle after `mem_rd_en`
- `a_valid` out 1: array input qualifier
- `a_drain` out 1: high during drain cycles
- `a_out` out `ARRAY_DIM`*`DATA_W`: lane k = bits [k*`DATA_W` +: `DATA_W`]

## Operation
- Element (v,k) is at `base_addr` + v*`ARRAY_DIM` + k, computed modulo 2^`ADDR_W` (wraps past top to 0).
- L = `num_vecs`*`ARRAY_DIM`; F = `num_vecs`+`ARRAY_DIM`-1.
- States and transitions:
  - IDLE: outputs idle.
    - `start` with legal `num_vecs` latches `base_addr`/`num_vecs` → LOAD.
    - `start` with `num_vecs`=0 or >`MAX_VECS` → pulse `cfg_err` next cycle, remain IDLE.
  - LOAD, L+1 cycles:
    - Cycles 0..L-1: `mem_rd_en`=1, addresses ascending from base.
    - Cycle L: `mem_rd_en`=0; final read data captured.
    - → FEED.
  - FEED, F cycles, f = 0..F-1:
    - `a_valid`=1.
    - Lane k = buf[f-k][k] when 0 ≤ f-k < `num_vecs`, else 0.
  - DRAIN, `ARRAY_DIM` cycles: `a_valid`=1, `a_drain`=1, all lanes 0.
  - DONE, 1 cycle: `done`=1, `busy`=0 → IDLE.
- `start` outside IDLE is ignored (no error, no restart). `start` in the DONE cycle is also ignored.
- Upper `MEM_W`-`DATA_W` bits of read data are discarded.

## Timing
- Reset values: `busy`, `done`, `cfg_err`, `mem_rd_en`, `a_valid`, `a_drain` = 0; `mem_rd_addr` = 0; `a_out` = 0. State = IDLE.
- Local buffer is not reset.
- All outputs are registered; `a_out` changes only at state/cycle boundaries defined above.
- Start sampled at edge E: LOAD occupies cycles E+1..E+L+1. FEED follows, then DRAIN, then DONE.
- Start-to-`done` latency = L + F + `ARRAY_DIM` + 2 cycles.
- Reset asserted mid-operation:
  - All outputs clear immediately (asynchronously).
  - No further memory reads are issued.
  - After release, the unit is in IDLE awaiting a fresh `start`.
- `num_vecs`=1, `ARRAY_DIM`=1: LOAD 2 cycles, FEED 1, DRAIN 1, DONE 1.

## Structure
- Shared `tpu_pkg`:
  - state enum `setup_state_t` (IDLE, LOAD, FEED, DRAIN, DONE)
  - defaults for `ARRAY_DIM`/`DATA_W`/`MEM_W`/`ADDR_W`
- One sub-module, `setup_buffer`: `MAX_VECS`×`ARRAY_DIM` register file of `DATA_W` entries.
  - One write port, fed by LOAD.
  - `ARRAY_DIM` combinational read ports, one per lane, indexed by f-k.
- Top module holds the FSM, read-address counter, feed counter f and drain counter.

## Test plan
- `ARRAY_DIM`=2, mem[15..18]=11,21,12,22; start base=15, num_vecs=2 → reads addr 15,16,17,18.
  - FEED (lane0,lane1) = (11,0), (12,21), (0,22).
  - 2 drain cycles of (0,0) with `a_drain`=1.
  - `done` 11 cycles after start edge.
- base=62, num_vecs=2, `ARRAY_DIM`=2 → read addresses 62,63,0,1 (wrap); lanes skew correctly.
- num_vecs=0, then num_vecs=`MAX_VECS`+1 → `cfg_err` pulse each time; `busy`/`mem_rd_en` stay 0.
- `start` pulsed during FEED of a running job → ignored; original job output and `done` timing unchanged.
- `reset` low during LOAD cycle 2 → all outputs 0 immediately. After release, a new start (num_vecs=1) completes normally with `done` at L+F+`ARRAY_DIM`+2.
- `ARRAY_DIM`=4, num_vecs=`MAX_VECS`=8 → F=11 feed cycles; lane k first nonzero at f=k, last at f=k+7; then 4 drain cycles.
